pixel_fetch_sequencer: RTL and testbench



---
 rtl/pixel_fetch_sequencer.sv | 157 +++++++++++++++
 tb/tb_pixel_fetch_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_sequencer.sv
// Initiator side of the grayscale fetch handshake: walks pixel addresses, captures
// each returned word and streams it to the input layer over valid/ready.
module pixel_fetch_sequencer #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] pixel_no,
    output logic              grayscale_fetch,
    input  logic              grayscale_fetched,
    input  logic [DATA_W-1:0] gray_scale,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] pix_index,
    output logic              pix_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [7:0]        TMO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] pixel_no_q, pixel_no_d;
    logic              fetch_q, fetch_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              last_q, last_d;
    logic [7:0]        tmo_q, tmo_d;

    logic fetch_hit;
    logic tmo_expire;
    logic xfer;

    // tmo_q is zero only on the first REQ edge, which doubles as the stale-flag guard.
    always_comb begin
        fetch_hit  = (state_q == S_REQ) && (tmo_q != '0) && grayscale_fetched;
        tmo_expire = (state_q == S_REQ) && !fetch_hit && ((tmo_q + 8'd1) == TMO_LIMIT);
        xfer       = (state_q == S_HOLD) && valid_q && pix_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            pixel_no_q <= '0;
            fetch_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            index_q    <= '0;
            last_q     <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            pixel_no_q <= pixel_no_d;
            fetch_q    <= fetch_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            index_q    <= index_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                if (fetch_hit) state_d = S_HOLD;
                else if (tmo_expire) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (xfer) state_d = last_q ? S_DONE : S_GAP;
            end
            S_GAP:  state_d = S_REQ;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered copies of the state being entered.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        fetch_d    = (state_d == S_REQ);
        valid_d    = (state_d == S_HOLD);
        error_d    = error_q;
        pixel_no_d = pixel_no_q;
        data_d     = data_q;
        index_d    = index_q;
        last_d     = last_q;
        tmo_d      = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d    = 1'b0;
                    pixel_no_d = '0;
                    tmo_d      = '0;
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + 8'd1;
                if (fetch_hit) begin
                    data_d  = gray_scale;
                    index_d = pixel_no_q;
                    last_d  = (pixel_no_q == LAST_ADDR);
                end else if (tmo_expire) begin
                    error_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (xfer) begin
                    last_d = 1'b0;
                    tmo_d  = '0;
                    if (!last_q) pixel_no_d = pixel_no_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign pixel_no        = pixel_no_q;
    assign grayscale_fetch = fetch_q;
    assign pix_valid       = valid_q;
    assign pix_data        = data_q;
    assign pix_index       = index_q;
    assign pix_last        = last_q;

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Directed bench for pixel_fetch_sequencer: a 3-edge-latency responder model feeds
// the DUT, and a scoreboard of expected pixels is checked at every downstream transfer.
module tb_pixel_fetch_sequencer;

    localparam int NPIX = 784;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, error;
    logic [9:0]  pixel_no;
    logic        grayscale_fetch;
    logic        grayscale_fetched;
    logic [15:0] gray_scale;
    logic        pix_valid, pix_ready;
    logic [15:0] pix_data;
    logic [9:0]  pix_index;
    logic        pix_last;

    always #5 clk = ~clk;

    pixel_fetch_sequencer #(
        .NUM_PIXELS(784),
        .ADDR_W    (10),
        .DATA_W    (16),
        .TIMEOUT   (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .pixel_no         (pixel_no),
        .grayscale_fetch  (grayscale_fetch),
        .grayscale_fetched(grayscale_fetched),
        .gray_scale       (gray_scale),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_data         (pix_data),
        .pix_index        (pix_index),
        .pix_last         (pix_last)
    );

    // Responder: counts 0..2 while fetch is high, raises fetched on count==2.
    logic [1:0] rcnt;
    logic       stale_hold;
    logic       hang_en;
    logic [9:0] hang_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt              <= 2'd0;
            grayscale_fetched <= 1'b0;
            gray_scale        <= 16'h0000;
        end else if (!grayscale_fetch) begin
            rcnt <= 2'd0;
            if (stale_hold) begin
                grayscale_fetched <= 1'b1;
                gray_scale        <= 16'hDEAD;
            end else begin
                grayscale_fetched <= 1'b0;
            end
        end else if (rcnt == 2'd2) begin
            if (!(hang_en && pixel_no == hang_addr)) begin
                grayscale_fetched <= 1'b1;
                gray_scale        <= {8'h00, pixel_no[7:0]};
            end
        end else begin
            rcnt              <= rcnt + 2'd1;
            grayscale_fetched <= 1'b0;
        end
    end

    typedef struct {
        logic [15:0] data;
        logic [9:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_image(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = 16'(i % 256);
            e.idx  = 10'(i);
            e.last = (i == NPIX - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_px(input int px, input int lim);
        int k;
        k = 0;
        while (!(pixel_no == 10'(px) && grayscale_fetch) && k < lim) begin
            tick();
            k++;
        end
        chk($sformatf("reach_px%0d", px), 32'(pixel_no == 10'(px) && grayscale_fetch), 1);
    endtask

    task automatic wait_valid(input int lim);
        int k;
        k = 0;
        while (!pix_valid && k < lim) begin
            tick();
            k++;
        end
        chk("wait_valid", pix_valid, 1);
    endtask

    task automatic wait_done(input int base, input int lim);
        int k;
        k = 0;
        while (done_cnt == base && k < lim) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(done_cnt > base), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (pix_valid && pix_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL sb_underflow observed_idx=%0d expected=none", pix_index);
                    end else begin
                        m = sb.pop_front();
                        chk("pix_data", pix_data, m.data);
                        chk("pix_index", pix_index, m.idx);
                        chk("pix_last", pix_last, m.last);
                    end
                    xfer_cnt++;
                end
            end
        end
    end

    initial begin : stim
        int base_x, base_d, s_cyc, n;
        rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
        stale_hold = 1'b0; hang_en = 1'b0; hang_addr = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_pixel_no", pixel_no, 0);
        chk("rst_fetch", grayscale_fetch, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_index", pix_index, 0);
        chk("rst_last", pix_last, 0);
        rst = 1'b0;
        tick();

        // Nominal scan, with an ignored start at pixel 50.
        push_image(NPIX);
        base_x = xfer_cnt; base_d = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        s_cyc = cyc;
        chk("start_busy", busy, 1);
        chk("start_fetch", grayscale_fetch, 1);
        chk("start_pixel_no", pixel_no, 0);
        wait_px(50, 400);
        start = 1'b1; tick(); start = 1'b0;
        chk("busy_start_px", pixel_no, 50);
        chk("busy_start_fetch", grayscale_fetch, 1);
        wait_done(base_d, 6000);
        chk("done_latency", 32'(done_cyc - s_cyc), 32'(783 * 6 + 5));
        chk("done_one_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("no_wrap_px", pixel_no, 783);
        chk("nom_error", error, 0);
        repeat (20) tick();
        chk("nom_done_cnt", 32'(done_cnt - base_d), 1);
        chk("nom_xfers", 32'(xfer_cnt - base_x), NPIX);
        chk("nom_sb_empty", sb.size(), 0);
        chk("nom_not_requeued", busy, 0);

        // Backpressure at pixel 5, then reset while holding pixel 300.
        push_image(NPIX);
        base_x = xfer_cnt; base_d = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        wait_px(5, 100);
        pix_ready = 1'b0;
        wait_valid(10);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", pix_valid, 1);
            chk("bp_data", pix_data, 5);
            chk("bp_index", pix_index, 5);
            chk("bp_fetch", grayscale_fetch, 0);
            chk("bp_pixel_no", pixel_no, 5);
            tick();
        end
        pix_ready = 1'b1;
        tick();
        chk("bp_post_valid", pix_valid, 0);
        chk("bp_gap_fetch", grayscale_fetch, 0);
        chk("bp_next_px", pixel_no, 6);
        tick();
        chk("bp_req_fetch", grayscale_fetch, 1);
        chk("bp_req_px", pixel_no, 6);
        wait_px(300, 2500);
        pix_ready = 1'b0;
        wait_valid(10);
        chk("hold300_index", pix_index, 300);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_error", error, 0);
        chk("arst_pixel_no", pixel_no, 0);
        chk("arst_fetch", grayscale_fetch, 0);
        chk("arst_valid", pix_valid, 0);
        chk("arst_data", pix_data, 0);
        chk("arst_index", pix_index, 0);
        chk("arst_last", pix_last, 0);
        chk("arst_xfers", 32'(xfer_cnt - base_x), 300);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix_ready = 1'b1;
        tick();
        chk("arst_no_done", 32'(done_cnt - base_d), 0);

        // Stale fetched at start, then a fetch that never completes at pixel 100.
        push_image(100);
        hang_en = 1'b1; hang_addr = 10'd100;
        base_x = xfer_cnt; base_d = done_cnt;
        stale_hold = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; stale_hold = 1'b0;
        chk("stale_fetch", grayscale_fetch, 1);
        chk("stale_px", pixel_no, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_nocap", pix_valid, 0);
        end
        tick();
        chk("stale_cap_valid", pix_valid, 1);
        chk("stale_cap_data", pix_data, 0);
        chk("stale_cap_index", pix_index, 0);
        wait_px(100, 700);
        n = 0;
        while (grayscale_fetch && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 15);
        chk("tmo_error", error, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_fetch", grayscale_fetch, 0);
        chk("tmo_valid", pix_valid, 0);
        chk("tmo_xfers", 32'(xfer_cnt - base_x), 100);
        chk("tmo_sb_empty", sb.size(), 0);
        repeat (3) tick();
        chk("tmo_sticky", error, 1);
        chk("tmo_no_done", 32'(done_cnt - base_d), 0);

        hang_en = 1'b0;
        push_image(NPIX);
        base_x = xfer_cnt; base_d = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_error_clr", error, 0);
        chk("restart_px", pixel_no, 0);
        chk("restart_busy", busy, 1);
        wait_done(base_d, 6000);
        tick();
        chk("restart_xfers", 32'(xfer_cnt - base_x), NPIX);
        chk("restart_sb_empty", sb.size(), 0);
        chk("restart_done_cnt", 32'(done_cnt - base_d), 1);
        chk("restart_error", error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
